// File: rtl/div16q24.sv
// Unsigned 16/16 divider producing a Q1.23 quotient by radix-2 restoring division (optional rounding: DIV16Q24_ROUND_EN).
// Latency: iv captured at edge k -> qout/ov valid in the cycle after edge k+25. No backpressure; iv outside IDLE is dropped.
module div16q24 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ain,
    input  logic [15:0] bin,
    input  logic        iv,
    output logic [23:0] qout,
    output logic        ov
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] dvsr;
    logic [16:0] rem;
    logic [23:0] quo;
    logic [4:0]  cnt;
    logic        sat;

    logic [16:0] trial;
    logic [16:0] diff;
    logic        ge;
    logic [23:0] res;

    // The first step compares the raw dividend (integer bit); later steps shift the remainder.
    always_comb begin
        trial = (cnt == 5'd0) ? rem : {rem[15:0], 1'b0};
        ge    = (trial >= {1'b0, dvsr});
        diff  = trial - {1'b0, dvsr};
    end

`ifdef DIV16Q24_ROUND_EN
    logic        rbit;
    logic [24:0] rsum;

    // The 25th quotient bit falls out of the final remainder, so rounding costs no extra cycle.
    always_comb begin
        rbit = ({rem[15:0], 1'b0} >= {1'b0, dvsr});
        rsum = {1'b0, quo} + {24'd0, rbit};
        res  = (sat || rsum[24]) ? 24'hFFFFFF : rsum[23:0];
    end
`else
    always_comb begin
        res = sat ? 24'hFFFFFF : quo;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iv) state_nxt = RUN;
            RUN:     if (cnt == 5'd23) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dvsr  <= 16'd0;
            rem   <= 17'd0;
            quo   <= 24'd0;
            cnt   <= 5'd0;
            sat   <= 1'b0;
            qout  <= 24'd0;
            ov    <= 1'b0;
        end else begin
            state <= state_nxt;
            ov    <= 1'b0;
            case (state)
                IDLE: begin
                    if (iv) begin
                        dvsr <= bin;
                        rem  <= {1'b0, ain};
                        quo  <= 24'd0;
                        cnt  <= 5'd0;
                        // Quotient would need a second integer bit (or is undefined): clamp.
                        sat  <= (bin == 16'd0) || ({1'b0, ain} >= {bin, 1'b0});
                    end
                end
                RUN: begin
                    rem <= ge ? diff : trial;
                    quo <= {quo[22:0], ge};
                    cnt <= cnt + 5'd1;
                end
                DONE: begin
                    qout <= res;
                    ov   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div16q24.sv
// Scoreboard bench for div16q24: driver pushes model results, negedge monitor pops and compares on ov.
module tb_div16q24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv = 1'b0;
    logic [15:0] ain = 16'd0;
    logic [15:0] bin = 16'd0;
    logic [23:0] qout;
    logic        ov;

    div16q24 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ain  (ain),
        .bin  (bin),
        .iv   (iv),
        .qout (qout),
        .ov   (ov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] q;
        int          at;
        bit          series;
        bit          first;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          done = 1'b0;
    logic [23:0] last_q = 24'd0;
    logic [23:0] prev_s = 24'd0;

    function automatic logic [23:0] model(input logic [15:0] a, input logic [15:0] b);
        longint unsigned la, lb, n;
        la = 64'(a);
        lb = 64'(b);
        if (lb == 0) return 24'hFFFFFF;
`ifdef DIV16Q24_ROUND_EN
        n = (((la << 24) / lb) + 1) >> 1;
`else
        n = (la << 23) / lb;
`endif
        if (n > 64'hFFFFFF) return 24'hFFFFFF;
        return n[23:0];
    endfunction

    task automatic start(input logic [15:0] a, input logic [15:0] b, input bit series, input bit first);
        exp_t e;
        @(negedge clk);
        ain = a;
        bin = b;
        iv  = 1'b1;
        @(posedge clk);
        #1;
        e.q = model(a, b);
        e.at = cyc + 25;
        e.series = series;
        e.first = first;
        sb.push_back(e);
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic stray(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        ain = a;
        bin = b;
        iv  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor / checker
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("drained_queue", 32'(sb.size()), 32'd0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end else if (!rst_n) begin
            chk("reset_qout", {8'd0, qout}, 32'd0);
            chk("reset_ov", {31'd0, ov}, 32'd0);
            sb.delete();
            last_q = 24'd0;
        end else if (ov) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_ov: got ov=1 qout=%h, expected no pulse (cycle %0d)", qout, cyc);
            end else begin
                e = sb.pop_front();
                chk("qout", {8'd0, qout}, {8'd0, e.q});
                chk("latency", cyc, e.at);
                if (e.series && !e.first) begin
                    n_tests++;
                    if (!(qout < prev_s)) begin
                        n_fail++;
                        $display("FAIL monotonic: got %h, expected below %h", qout, prev_s);
                    end
                end
                if (e.series) prev_s = qout;
            end
            last_q = qout;
        end else begin
            chk("hold", {8'd0, qout}, {8'd0, last_q});
        end
    end

    initial begin
        #22 rst_n = 1'b1;

        start(16'h4000, 16'h8000, 0, 0); gap(25);
        start(16'hB504, 16'hB504, 0, 0); gap(25);
        start(16'h0001, 16'hFFFF, 0, 0); gap(25);
        start(16'h0001, 16'h0003, 0, 0); gap(25);
        start(16'hFFFF, 16'h0001, 0, 0); gap(25);
        start(16'h1234, 16'h0000, 0, 0); gap(25);
        start(16'h0000, 16'h0001, 0, 0); gap(25);
        start(16'hFFFF, 16'h8000, 0, 0); gap(25);
        start(16'h0001, 16'h0001, 0, 0); gap(30);

        for (int i = 0; i < 8; i++) begin
            start(16'hB504, 16'(16'hB04F + i), 1, i == 0);
            if (i == 3) begin
                gap(9);
                stray(16'h0001, 16'h0000);
                gap(25);
            end else begin
                gap(35);
            end
        end

        for (int i = 0; i < 30; i++) begin
            logic [15:0] a, b;
            b = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom_range(0, 15));
                1: a = 16'($urandom);
                default: a = 16'($urandom_range(0, 2 * int'(b) - 1 < 0 ? 0 : (2 * int'(b) - 1 > 65535 ? 65535 : 2 * int'(b) - 1)));
            endcase
            if (b < 16) a = 16'($urandom);
            start(a, b, 0, 0);
            gap(25 + $urandom_range(0, 8));
        end

        start(16'hB504, 16'hB04F, 0, 0);
        gap(11);
        #2 rst_n = 1'b0;
        gap(3);
        #2 rst_n = 1'b1;
        start(16'h0001, 16'h0003, 0, 0);
        gap(40);
        done = 1'b1;
    end

endmodule
